// File: rtl/alu_pkg.sv
// Shared types for the ALU issue stage: operation codes, opcodes, slot record.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package alu_pkg;

   // 4-bit ALU operation codes; bit 3 selects the "alternate" form (SUB/SRA).
   typedef enum logic [3:0] {
      ALU_ADD  = 4'b0000,
      ALU_SLL  = 4'b0001,
      ALU_SLT  = 4'b0010,
      ALU_SLTU = 4'b0011,
      ALU_XOR  = 4'b0100,
      ALU_SRL  = 4'b0101,
      ALU_OR   = 4'b0110,
      ALU_AND  = 4'b0111,
      ALU_SUB  = 4'b1000,
      ALU_SRA  = 4'b1101,
      ALU_DBG  = 4'b1111
   } alu_op_e;

   // RV32I major opcodes handled by the stage.
   localparam logic [6:0] OPC_OP      = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM  = 7'b0010011;
   localparam logic [6:0] OPC_LUI     = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC   = 7'b0010111;
   localparam logic [6:0] OPC_JAL     = 7'b1101111;
   localparam logic [6:0] OPC_JALR    = 7'b1100111;
   localparam logic [6:0] OPC_LOAD    = 7'b0000011;
   localparam logic [6:0] OPC_STORE   = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH  = 7'b1100011;
   localparam logic [6:0] OPC_CUSTOM0 = 7'b0001011;

   localparam logic [6:0] F7_BASE = 7'b0000000;
   localparam logic [6:0] F7_ALT  = 7'b0100000;

   // Stage state.
   typedef enum logic {
      STATE_RUN  = 1'b0,
      STATE_TRAP = 1'b1
   } stage_state_e;

   // Contents of the ID/EX slot; every field maps straight to an output port.
   typedef struct packed {
      logic        vld;
      logic [31:0] op1;
      logic [31:0] op2;
      alu_op_e     op;
      logic [4:0]  rd;
      logic        reg_write;
      logic        trap;
   } slot_t;

endpackage

// File: rtl/alu_issue_stage_imm_gen.sv
// Immediate generator: picks the I, S or U immediate according to the opcode.
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of instr_i.
//
// Ports:
//   instr_i  32-bit instruction word
//   imm_o    32-bit immediate (I: LOAD/OP-IMM/JALR, S: STORE, U: LUI/AUIPC, else 0)
module imm_gen
   import alu_pkg::*;
(
   input  logic [31:0] instr_i,
   output logic [31:0] imm_o
);

   logic [31:0] imm_i_type;
   logic [31:0] imm_s_type;
   logic [31:0] imm_u_type;

   assign imm_i_type = {{20{instr_i[31]}}, instr_i[31:20]};
   assign imm_s_type = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
   assign imm_u_type = {instr_i[31:12], 12'b0};

   always_comb begin
      imm_o = 32'b0;
      case (instr_i[6:0])
         OPC_OP_IMM, OPC_LOAD, OPC_JALR: imm_o = imm_i_type;
         OPC_STORE:                      imm_o = imm_s_type;
         OPC_LUI, OPC_AUIPC:             imm_o = imm_u_type;
         default:                        imm_o = 32'b0;
      endcase
   end

endmodule

// File: rtl/alu_issue_stage.sv
// RV32I decode-to-execute issue stage: decodes, selects ALU operands and op, registers one ID/EX slot.
// Latency: 1 cycle input to outputs; 1 instruction per cycle.
// Backpressure: ready_o low while stall_i is high or the stage is frozen in TRAP (until flush_i).
//
// Ports:
//   clk_i, rst_i (sync, active-high)
//   valid_i, ready_o, instr_i, pc_i, rs1_data_i, rs2_data_i   -- decode-side input
//   stall_i (hold slot), flush_i (kill slot, clear trap)
//   valid_o, alu_op1_o, alu_op2_o, alu_operation_o, rd_o, reg_write_o, trap_o -- slot outputs
// Build option: ALU_DEBUG_OP_EN makes custom-0 decode to the DBG op instead of trapping.
module alu_issue_stage
   import alu_pkg::*;
(
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        valid_i,
   output logic        ready_o,
   input  logic [31:0] instr_i,
   input  logic [31:0] pc_i,
   input  logic [31:0] rs1_data_i,
   input  logic [31:0] rs2_data_i,
   input  logic        stall_i,
   input  logic        flush_i,
   output logic        valid_o,
   output logic [31:0] alu_op1_o,
   output logic [31:0] alu_op2_o,
   output logic [3:0]  alu_operation_o,
   output logic [4:0]  rd_o,
   output logic        reg_write_o,
   output logic        trap_o
);

   localparam logic [0:0] S_RUN  = STATE_RUN;
   localparam logic [0:0] S_TRAP = STATE_TRAP;

   logic [6:0]  opcode;
   logic [2:0]  funct3;
   logic [6:0]  funct7;
   logic [4:0]  rd;
   logic [31:0] shamt_ext;
   logic [31:0] imm;

   // rs1 index is resolved upstream; only its data arrives here.
   logic        unused_rs1_field;

   logic        d_legal;
   alu_op_e     d_op;
   logic [31:0] d_op1;
   logic [31:0] d_op2;
   logic        d_rw;

   slot_t       slot_q;
   slot_t       slot_d;
   logic [0:0]  state_q;

   assign opcode           = instr_i[6:0];
   assign rd               = instr_i[11:7];
   assign funct3           = instr_i[14:12];
   assign funct7           = instr_i[31:25];
   assign shamt_ext        = {27'b0, instr_i[24:20]};
   assign unused_rs1_field = ^instr_i[19:15];

   imm_gen u_imm_gen (
      .instr_i (instr_i),
      .imm_o   (imm)
   );

   // Decode: legality, operation and operand selection.
   always_comb begin
      d_legal = 1'b0;
      d_op    = ALU_ADD;
      d_op1   = 32'b0;
      d_op2   = 32'b0;
      d_rw    = 1'b0;
      case (opcode)
         OPC_OP: begin
            // Alternate funct7 only exists for SUB and SRA.
            d_legal = (funct7 == F7_BASE) ||
                      ((funct7 == F7_ALT) && ((funct3 == 3'b000) || (funct3 == 3'b101)));
            d_op    = alu_op_e'({funct7[5], funct3});
            d_op1   = rs1_data_i;
            d_op2   = rs2_data_i;
            d_rw    = 1'b1;
         end
         OPC_OP_IMM: begin
            d_op1 = rs1_data_i;
            d_rw  = 1'b1;
            if (funct3 == 3'b001) begin
               d_legal = (funct7 == F7_BASE);
               d_op    = ALU_SLL;
               d_op2   = shamt_ext;
            end else if (funct3 == 3'b101) begin
               d_legal = (funct7 == F7_BASE) || (funct7 == F7_ALT);
               d_op    = funct7[5] ? ALU_SRA : ALU_SRL;
               d_op2   = shamt_ext;
            end else begin
               // funct7 bits are immediate bits here, so they never select SUB.
               d_legal = 1'b1;
               d_op    = alu_op_e'({1'b0, funct3});
               d_op2   = imm;
            end
         end
         OPC_LUI: begin
            d_legal = 1'b1;
            d_op2   = imm;
            d_rw    = 1'b1;
         end
         OPC_AUIPC: begin
            d_legal = 1'b1;
            d_op1   = pc_i;
            d_op2   = imm;
            d_rw    = 1'b1;
         end
         OPC_JAL, OPC_JALR: begin
            // The ALU computes the link address pc+4; target is handled elsewhere.
            d_legal = (opcode == OPC_JAL) || (funct3 == 3'b000);
            d_op1   = pc_i;
            d_op2   = 32'd4;
            d_rw    = 1'b1;
         end
         OPC_LOAD: begin
            d_legal = (funct3 != 3'b011) && (funct3 != 3'b110) && (funct3 != 3'b111);
            d_op1   = rs1_data_i;
            d_op2   = imm;
            d_rw    = 1'b1;
         end
         OPC_STORE: begin
            d_legal = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010);
            d_op1   = rs1_data_i;
            d_op2   = imm;
         end
         OPC_BRANCH: begin
            d_legal = (funct3 != 3'b010) && (funct3 != 3'b011);
            d_op    = ALU_SUB;
            d_op1   = rs1_data_i;
            d_op2   = rs2_data_i;
         end
`ifdef ALU_DEBUG_OP_EN
         OPC_CUSTOM0: begin
            d_legal = 1'b1;
            d_op    = ALU_DBG;
            d_rw    = 1'b1;
         end
`endif
         default: d_legal = 1'b0;
      endcase
   end

   // Next slot value when the stage accepts (RUN, no stall, no flush).
   always_comb begin
      slot_d = '0;
      if (valid_i) begin
         if (d_legal) begin
            slot_d.vld       = 1'b1;
            slot_d.op1       = d_op1;
            slot_d.op2       = d_op2;
            slot_d.op        = d_op;
            slot_d.rd        = rd;
            slot_d.reg_write = d_rw && (rd != 5'd0);
         end else begin
            // Captured illegal instruction: dead slot with only the trap flag.
            slot_d.trap = 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         slot_q  <= '0;
         state_q <= S_RUN;
      end else if (flush_i) begin
         slot_q  <= '0;
         state_q <= S_RUN;
      end else if (stall_i) begin
         slot_q  <= slot_q;
         state_q <= state_q;
      end else if (state_q == S_RUN) begin
         slot_q  <= slot_d;
         state_q <= (valid_i && !d_legal) ? S_TRAP : S_RUN;
      end
   end

   assign ready_o         = !stall_i && (state_q == S_RUN);
   assign valid_o         = slot_q.vld;
   assign alu_op1_o       = slot_q.op1;
   assign alu_op2_o       = slot_q.op2;
   assign alu_operation_o = slot_q.op;
   assign rd_o            = slot_q.rd;
   assign reg_write_o     = slot_q.reg_write;
   assign trap_o          = slot_q.trap;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Self-checking bench for alu_issue_stage: directed vector table, hand sequences, random vs. model.
// Latency: expects outputs one clock after inputs are presented.
// Backpressure: exercises stall, flush and trap freeze.
module tb_alu_issue_stage;

   logic        clk = 1'b0;
   logic        rst_i, valid_i, ready_o, stall_i, flush_i;
   logic [31:0] instr_i, pc_i, rs1_data_i, rs2_data_i;
   logic        valid_o, reg_write_o, trap_o;
   logic [31:0] alu_op1_o, alu_op2_o;
   logic [3:0]  alu_operation_o;
   logic [4:0]  rd_o;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   alu_issue_stage dut (
      .clk_i(clk), .rst_i(rst_i), .valid_i(valid_i), .ready_o(ready_o),
      .instr_i(instr_i), .pc_i(pc_i), .rs1_data_i(rs1_data_i), .rs2_data_i(rs2_data_i),
      .stall_i(stall_i), .flush_i(flush_i), .valid_o(valid_o),
      .alu_op1_o(alu_op1_o), .alu_op2_o(alu_op2_o), .alu_operation_o(alu_operation_o),
      .rd_o(rd_o), .reg_write_o(reg_write_o), .trap_o(trap_o)
   );

   typedef struct {
      logic [31:0] instr, pc, rs1, rs2;
      logic [3:0]  op;
      logic [31:0] op1, op2;
      logic [4:0]  rd;
      logic        rw;
   } vec_t;

   typedef struct {
      logic        legal;
      logic [3:0]  op;
      logic [31:0] op1, op2;
      logic        rw;
   } ref_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [31:0] ins, input logic [31:0] pc, input logic [31:0] r1,
                        input logic [31:0] r2, input logic v, input logic st, input logic fl);
      instr_i = ins; pc_i = pc; rs1_data_i = r1; rs2_data_i = r2;
      valid_i = v; stall_i = st; flush_i = fl;
   endtask

   function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
         input logic [4:0] rs1, input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] opc);
      return {f7, rs2, rs1, f3, rd, opc};
   endfunction

   function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
         input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] opc);
      return {imm, rs1, f3, rd, opc};
   endfunction

   function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
         input logic [4:0] rs1, input logic [2:0] f3, input logic [6:0] opc);
      return {imm[11:5], rs2, rs1, f3, imm[4:0], opc};
   endfunction

   // Reference decode written straight from the ISA rules.
   function automatic ref_t model(input logic [31:0] ins, input logic [31:0] pc,
                                  input logic [31:0] r1, input logic [31:0] r2);
      ref_t r;
      logic [6:0]  opc = ins[6:0];
      logic [2:0]  f3  = ins[14:12];
      logic [6:0]  f7  = ins[31:25];
      logic [31:0] iimm = {{20{ins[31]}}, ins[31:20]};
      logic [31:0] simm = {{20{ins[31]}}, ins[31:25], ins[11:7]};
      logic [31:0] uimm = {ins[31:12], 12'h000};
      r = '{legal: 1'b0, op: 4'h0, op1: 32'h0, op2: 32'h0, rw: 1'b0};
      case (opc)
         7'h33: begin
            r.legal = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
            r.op = {f7[5], f3}; r.op1 = r1; r.op2 = r2; r.rw = 1'b1;
         end
         7'h13: begin
            r.op1 = r1; r.rw = 1'b1;
            if (f3 == 3'd1) begin
               r.legal = (f7 == 7'h00); r.op = 4'b0001; r.op2 = 32'(ins[24:20]);
            end else if (f3 == 3'd5) begin
               r.legal = (f7 == 7'h00) || (f7 == 7'h20);
               r.op = (f7 == 7'h20) ? 4'b1101 : 4'b0101; r.op2 = 32'(ins[24:20]);
            end else begin
               r.legal = 1'b1; r.op = {1'b0, f3}; r.op2 = iimm;
            end
         end
         7'h37: begin r.legal = 1'b1; r.op2 = uimm; r.rw = 1'b1; end
         7'h17: begin r.legal = 1'b1; r.op1 = pc; r.op2 = uimm; r.rw = 1'b1; end
         7'h6F: begin r.legal = 1'b1; r.op1 = pc; r.op2 = 4; r.rw = 1'b1; end
         7'h67: begin r.legal = (f3 == 3'd0); r.op1 = pc; r.op2 = 4; r.rw = 1'b1; end
         7'h03: begin
            r.legal = f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
            r.op1 = r1; r.op2 = iimm; r.rw = 1'b1;
         end
         7'h23: begin r.legal = (f3 < 3'd3); r.op1 = r1; r.op2 = simm; end
         7'h63: begin
            r.legal = !(f3 inside {3'd2, 3'd3}); r.op = 4'b1000; r.op1 = r1; r.op2 = r2;
         end
`ifdef ALU_DEBUG_OP_EN
         7'h0B: begin r.legal = 1'b1; r.op = 4'b1111; r.rw = 1'b1; end
`endif
         default: r.legal = 1'b0;
      endcase
      if (ins[11:7] == 5'd0) r.rw = 1'b0;
      return r;
   endfunction

   task automatic chk_slot(input string tag, input logic v, input logic [3:0] op,
         input logic [31:0] op1, input logic [31:0] op2, input logic [4:0] rd,
         input logic rw, input logic tr);
      chk({tag, ".valid"}, 32'(valid_o), 32'(v));
      chk({tag, ".op"}, 32'(alu_operation_o), 32'(op));
      chk({tag, ".op1"}, alu_op1_o, op1);
      chk({tag, ".op2"}, alu_op2_o, op2);
      chk({tag, ".rd"}, 32'(rd_o), 32'(rd));
      chk({tag, ".rw"}, 32'(reg_write_o), 32'(rw));
      chk({tag, ".trap"}, 32'(trap_o), 32'(tr));
   endtask

   vec_t vecs[13];
   logic [31:0] ins;
   logic [6:0]  opcs[11];
   ref_t        e;
   logic        v;

   initial begin
      vecs[0]  = '{enc_r(7'h00, 5'd2, 5'd1, 3'd0, 5'd3, 7'h33), 32'h0, 32'd5, 32'd7,
                   4'b0000, 32'd5, 32'd7, 5'd3, 1'b1};
      vecs[1]  = '{enc_r(7'h20, 5'd2, 5'd1, 3'd0, 5'd4, 7'h33), 32'h0, 32'd10, 32'd3,
                   4'b1000, 32'd10, 32'd3, 5'd4, 1'b1};
      vecs[2]  = '{enc_i(12'h404, 5'd6, 3'd5, 5'd5, 7'h13), 32'h0, 32'hF0000000, 32'h0,
                   4'b1101, 32'hF0000000, 32'd4, 5'd5, 1'b1};
      vecs[3]  = '{enc_i(12'hFFF, 5'd0, 3'd0, 5'd1, 7'h13), 32'h0, 32'h0, 32'h0,
                   4'b0000, 32'h0, 32'hFFFFFFFF, 5'd1, 1'b1};
      vecs[4]  = '{{20'h12345, 5'd1, 7'h17}, 32'h100, 32'h55, 32'h66,
                   4'b0000, 32'h100, 32'h12345000, 5'd1, 1'b1};
      vecs[5]  = '{{20'h00800, 5'd1, 7'h6F}, 32'h200, 32'h55, 32'h66,
                   4'b0000, 32'h200, 32'd4, 5'd1, 1'b1};
      vecs[6]  = '{{20'hABCDE, 5'd7, 7'h37}, 32'h300, 32'h55, 32'h66,
                   4'b0000, 32'h0, 32'hABCDE000, 5'd7, 1'b1};
      vecs[7]  = '{enc_s(12'hFF8, 5'd2, 5'd9, 3'd2, 7'h23), 32'h0, 32'h1000, 32'h77,
                   4'b0000, 32'h1000, 32'hFFFFFFF8, 5'd24, 1'b0};
      vecs[8]  = '{enc_r(7'h00, 5'd2, 5'd1, 3'd0, 5'd0, 7'h63), 32'h0, 32'd9, 32'd4,
                   4'b1000, 32'd9, 32'd4, 5'd0, 1'b0};
      vecs[9]  = '{enc_r(7'h00, 5'd2, 5'd1, 3'd0, 5'd0, 7'h33), 32'h0, 32'd1, 32'd2,
                   4'b0000, 32'd1, 32'd2, 5'd0, 1'b0};
      vecs[10] = '{enc_i(12'hFFB, 5'd1, 3'd3, 5'd8, 7'h13), 32'h0, 32'd20, 32'h0,
                   4'b0011, 32'd20, 32'hFFFFFFFB, 5'd8, 1'b1};
      vecs[11] = '{enc_i(12'd16, 5'd2, 3'd2, 5'd9, 7'h03), 32'h0, 32'h2000, 32'h0,
                   4'b0000, 32'h2000, 32'd16, 5'd9, 1'b1};
      vecs[12] = '{enc_r(7'h00, 5'd2, 5'd1, 3'd7, 5'd10, 7'h33), 32'h0, 32'hF0F0, 32'hFF00,
                   4'b0111, 32'hF0F0, 32'hFF00, 5'd10, 1'b1};

      opcs = '{7'h33, 7'h13, 7'h37, 7'h17, 7'h6F, 7'h67, 7'h03, 7'h23, 7'h63, 7'h7F, 7'h0B};

      // Reset
      rst_i = 1'b1;
      drive(32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
      tick(); tick();
      chk_slot("reset", 1'b0, 4'h0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0);
      chk("reset.ready", 32'(ready_o), 32'd1);
      rst_i = 1'b0;

      // Directed vector table
      for (int i = 0; i < 13; i++) begin
         drive(vecs[i].instr, vecs[i].pc, vecs[i].rs1, vecs[i].rs2, 1'b1, 1'b0, 1'b0);
         tick();
         chk_slot($sformatf("vec%0d", i), 1'b1, vecs[i].op, vecs[i].op1, vecs[i].op2,
                  vecs[i].rd, vecs[i].rw, 1'b0);
      end

      // Bubble: legal encoding with valid_i=0 loads zeros
      drive(vecs[0].instr, 32'h0, 32'd5, 32'd7, 1'b0, 1'b0, 1'b0);
      tick();
      chk_slot("bubble", 1'b0, 4'h0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0);

      // Stall hold for 3 cycles while inputs change
      drive(vecs[0].instr, 32'h0, 32'd5, 32'd7, 1'b1, 1'b0, 1'b0);
      tick();
      for (int i = 0; i < 3; i++) begin
         drive(vecs[1 + i].instr, 32'h40, 32'($urandom), 32'($urandom), 1'b1, 1'b1, 1'b0);
         #1 chk("stall.ready", 32'(ready_o), 32'd0);
         tick();
         chk_slot($sformatf("stall%0d", i), 1'b1, 4'h0, 32'd5, 32'd7, 5'd3, 1'b1, 1'b0);
      end
      // Flush together with stall
      drive(vecs[0].instr, 32'h0, 32'd5, 32'd7, 1'b1, 1'b1, 1'b1);
      tick();
      chk_slot("flush_stall", 1'b0, 4'h0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0);

      // Illegal opcode 0x7F traps and freezes
      drive(32'h0000007F, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
      tick();
      chk("ill.trap", 32'(trap_o), 32'd1);
      chk("ill.valid", 32'(valid_o), 32'd0);
      chk("ill.rw", 32'(reg_write_o), 32'd0);
      chk("ill.ready", 32'(ready_o), 32'd0);
      for (int i = 0; i < 2; i++) begin
         drive(vecs[i].instr, vecs[i].pc, vecs[i].rs1, vecs[i].rs2, 1'b1, 1'b0, 1'b0);
         tick();
         chk("frozen.trap", 32'(trap_o), 32'd1);
         chk("frozen.valid", 32'(valid_o), 32'd0);
         chk("frozen.ready", 32'(ready_o), 32'd0);
      end
      drive(32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
      tick();
      flush_i = 1'b0;
      #1;
      chk("unfreeze.trap", 32'(trap_o), 32'd0);
      chk("unfreeze.ready", 32'(ready_o), 32'd1);

      // Illegal with valid_i=0 is ignored
      drive(32'h0000007F, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
      tick();
      chk("ill_novalid.trap", 32'(trap_o), 32'd0);
      chk("ill_novalid.ready", 32'(ready_o), 32'd1);

      // Flush wins over a simultaneous illegal instruction
      drive(32'h0000007F, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1);
      tick();
      flush_i = 1'b0; valid_i = 1'b0;
      #1;
      chk("flush_ill.trap", 32'(trap_o), 32'd0);
      chk("flush_ill.ready", 32'(ready_o), 32'd1);

      // Reset mid-trap
      drive(32'hFFFFFFFF, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
      tick();
      chk("pre_rst.trap", 32'(trap_o), 32'd1);
      rst_i = 1'b1; stall_i = 1'b1;
      tick();
      rst_i = 1'b0; stall_i = 1'b0; valid_i = 1'b0;
      #1;
      chk_slot("rst_trap", 1'b0, 4'h0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0);
      chk("rst_trap.ready", 32'(ready_o), 32'd1);

      // custom-0 with rd=4
      drive({25'h0000080, 7'h0B} | 32'h00000200, 32'h0, 32'd3, 32'd3, 1'b1, 1'b0, 1'b0);
      tick();
`ifdef ALU_DEBUG_OP_EN
      chk_slot("custom0", 1'b1, 4'b1111, 32'h0, 32'h0, 5'd4, 1'b1, 1'b0);
`else
      chk("custom0.trap", 32'(trap_o), 32'd1);
      chk("custom0.valid", 32'(valid_o), 32'd0);
      drive(32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
      tick();
`endif

      // Random instructions against the reference model
      for (int i = 0; i < 400; i++) begin
         ins = $urandom;
         ins[6:0] = opcs[$urandom_range(0, 10)];
         case ($urandom_range(0, 3))
            0: ins[31:25] = 7'h00;
            1: ins[31:25] = 7'h20;
            default: ;
         endcase
         v = ($urandom_range(0, 4) != 0);
         drive(ins, $urandom, $urandom, $urandom, v, 1'b0, 1'b0);
         e = model(ins, pc_i, rs1_data_i, rs2_data_i);
         tick();
         if (!v) begin
            chk_slot($sformatf("rnd%0d.bubble", i), 1'b0, 4'h0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0);
         end else if (e.legal) begin
            chk_slot($sformatf("rnd%0d", i), 1'b1, e.op, e.op1, e.op2, ins[11:7], e.rw, 1'b0);
         end else begin
            chk($sformatf("rnd%0d.trap", i), 32'(trap_o), 32'd1);
            chk($sformatf("rnd%0d.valid", i), 32'(valid_o), 32'd0);
            chk($sformatf("rnd%0d.ready", i), 32'(ready_o), 32'd0);
            drive(32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
            tick();
         end
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
